// File: rtl/seg_pkg.sv
// Shared display-code definitions for the 4-digit seven-segment path.
// Used by seg_scanner, seg_controller and the game FSM.
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int CODE_W     = 5;

   // One digit's display code: table select in the MSB, table entry below it.
   typedef struct packed {
      logic       other;
      logic [3:0] num;
   } seg_code_t;

   localparam logic [3:0] LTR_L = 4'd1;
   localparam logic [3:0] LTR_U = 4'd2;
   localparam logic [3:0] LTR_C = 4'd3;
   localparam logic [3:0] LTR_D = 4'd4;
   localparam logic [3:0] LTR_H = 4'd5;
   localparam logic [3:0] LTR_I = 4'd6;

   localparam seg_code_t CODE_BLANK = '{other: 1'b1, num: 4'd0};
   localparam seg_code_t CODE_L     = '{other: 1'b1, num: LTR_L};
   localparam seg_code_t CODE_U     = '{other: 1'b1, num: LTR_U};
   localparam seg_code_t CODE_C     = '{other: 1'b1, num: LTR_C};
   localparam seg_code_t CODE_D     = '{other: 1'b1, num: LTR_D};
   localparam seg_code_t CODE_H     = '{other: 1'b1, num: LTR_H};
   localparam seg_code_t CODE_I     = '{other: 1'b1, num: LTR_I};

   function automatic seg_code_t mk_code(input logic other, input logic [3:0] num);
      return '{other: other, num: num};
   endfunction

   // Active-low one-hot anode pattern for a digit index.
   function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/tc_counter.sv
// Modulo-N up-counter with a combinational terminal-count pulse.
// tc is high during the cycle the count sits at N-1 while enabled.
module tc_counter #(
   parameter int unsigned N = 4,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   assign tc = en && (count == LAST);

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples the pre-edge value of every other register, independent of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed 4-digit anode scanner with a frame-synchronous shadow buffer.
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg_scanner
   import seg_pkg::*;
#(
   parameter int unsigned DWELL     = 100000,
   parameter int unsigned GUARD     = 500,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [1:0]            wr_idx,
   input  logic [3:0]            wr_num,
   input  logic                  wr_other,
   input  logic                  commit,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
   output logic                  busy,
   output logic                  frame_tick,
   output logic [NUM_DIGITS-1:0] an,
   output logic [3:0]            num,
   output logic                  other
);

   localparam int CNT_W = $clog2(DWELL);
   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  dwell_tc;
   logic [1:0]            idx;
   logic [1:0]            idx_nxt;
   logic                  boundary;
   logic                  apply;
   seg_code_t             code_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;
   seg_code_t             active [NUM_DIGITS];
   seg_code_t             shadow [NUM_DIGITS];

   tc_counter #(.N(DWELL)) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .count (cnt),
      .tc    (dwell_tc)
   );

`ifdef SEG_BLINK_EN
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BLK_W-1:0] unused_blink_cnt;
   logic             blink_tc;
   logic             blink_phase;
   logic             blink_phase_nxt;

   tc_counter #(.N(BLINK_DIV)) u_blink (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .count (unused_blink_cnt),
      .tc    (blink_tc)
   );

   assign blink_phase_nxt = blink_phase ^ blink_tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_phase <= 1'b0;
      end else begin
         blink_phase <= blink_phase_nxt;
      end
   end
`else
   logic unused_blink_div;
   assign unused_blink_div = |BLINK_DIV;
`endif

   // The frame boundary is the dwell wrap that takes idx from 3 back to 0.
   assign boundary = dwell_tc && (idx == 2'd3);
   assign apply    = boundary && (busy || commit);

   // Outputs are registered from next-state values so that they line up
   // with the counter and index they describe, cycle for cycle.
   // NOTE: every signal written here gets a value on every path, so no latch.
   always_comb begin
      cnt_nxt  = dwell_tc ? '0 : cnt + 1'b1;
      idx_nxt  = dwell_tc ? idx + 2'd1 : idx;
      code_nxt = apply ? shadow[idx_nxt] : active[idx_nxt];
      an_nxt   = (cnt_nxt < GUARD_C) ? '1 : anode_sel(idx_nxt);
`ifdef SEG_BLINK_EN
      if (blink_phase_nxt && blink_mask[idx_nxt]) begin
         an_nxt = '1;
      end
`endif
   end

   // NOTE: the code buffers are only four entries and must power up dark,
   // so they are reset like ordinary registers rather than left as RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         busy       <= 1'b0;
         frame_tick <= 1'b0;
         an         <= '1;
         num        <= CODE_BLANK.num;
         other      <= CODE_BLANK.other;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            active[i] <= CODE_BLANK;
            shadow[i] <= CODE_BLANK;
         end
      end else begin
         idx        <= idx_nxt;
         frame_tick <= boundary;
         an         <= an_nxt;
         num        <= code_nxt.num;
         other      <= code_nxt.other;

         if (boundary) begin
            busy <= 1'b0;
         end else if (commit) begin
            busy <= 1'b1;
         end

         // The copy takes the pre-edge shadow; a write on the same edge waits.
         if (apply) begin
            active <= shadow;
         end
         if (wr_en) begin
            shadow[wr_idx] <= mk_code(wr_other, wr_num);
         end
      end
   end

endmodule

// File: doc/seg_scanner.md
Name: seg_scanner

Overview:
- Time-multiplexed driver for the Basys3 4-digit common-anode display.
- Holds one 5-bit display code per digit: {other, num[3:0]}.
- Cycles through the anodes and presents the selected digit's code on num/other, which feed seg_controller for decoding.
- Game logic writes codes into a shadow buffer; the shadow is committed to the displayed buffer only at a frame boundary, so a frame never tears.

Parameters:
- DWELL, 100000, clk cycles each digit is selected; must be ≥ GUARD+2.
- GUARD, 500, cycles at the start of each dwell with all anodes off (anti-ghosting); 0 disables the guard.
- BLINK_DIV, 25000000, clk cycles per blink half-period (used only with SEG_BLINK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one shadow entry this cycle
- wr_idx  in  2  shadow entry to write (0 = rightmost digit)
- wr_num  in  4  code value
- wr_other  in  1  0 = numeric table, 1 = letter table
- commit  in  1  one-cycle pulse: request shadow→active copy
- busy  out  1  commit pending (not yet applied)
- frame_tick  out  1  one-cycle pulse when the digit index wraps 3→0
- an  out  4  active-low anode enables
- num  out  4  code to seg_controller
- other  out  1  table select to seg_controller
- blink_mask  in  4  per-digit blink enable (only with SEG_BLINK_EN)

Behaviour:
- One clock, synchronous active-high reset; all state is updated on the rising edge of clk.
- Reset values:
  - dwell counter = 0, idx = 0, busy = 0, frame_tick = 0, an = 4'b1111.
  - num = 0, other = 1.
  - All active and shadow entries = BLANK {other = 1, num = 0}, so the display is dark after reset.
- Dwell counter counts 0..DWELL-1. At DWELL-1 it wraps to 0 and idx advances 0→1→2→3→0.
- Reset mid-operation: all state returns to the reset values in the same edge; a pending commit is discarded.
- Outputs an, num and other are registered and reflect the new idx on the cycle after the counter wraps.
- Anode drive:
  - While the counter is < GUARD: an = 4'b1111.
  - Otherwise: an = ~(4'b0001 << idx).
  - The cycle immediately after reset counts as counter = 0, so the guard applies.
- num/other always present active[idx], including during the guard.
- Shadow writes: when wr_en = 1, shadow[wr_idx] ← {wr_other, wr_num} at the next edge. Writes are accepted every cycle, whether or not a commit is pending.
- Commit handling:
  - A commit pulse sets busy. Further commit pulses while busy are absorbed, with no queueing.
  - At the frame boundary (the wrap where idx goes 3→0) with busy = 1: active ← shadow as it stands at that edge, then busy clears.
  - frame_tick pulses on the same edge regardless of busy.
- Simultaneous events:
  - commit on the boundary cycle: applied at that boundary; busy never asserts.
  - wr_en on the boundary cycle with a commit applying: the written value is not in that copy. It lands in shadow and appears at the next commit.
  - commit and wr_en in the same cycle, not at a boundary: the write is included in the pending copy.
- wr_num values ≥ 10 (numeric table) or ≥ 7 (letter table) are stored unchanged; decoding is seg_controller's job.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - blink_mask port exists.
  - A free-running blink counter over BLINK_DIV toggles blink_phase. Both reset to 0, phase 0 = visible.
  - When blink_phase = 1 and blink_mask[idx] = 1, an = 4'b1111 for the whole dwell.
  - num/other are unaffected.
- Not defined: no blink_mask port, no blink counter; an follows the guard rule only.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS = 4.
  - Code width 5 and the {other, num} packing.
  - Constants: BLANK = {1, 4'd0} and the letter codes L = 1, U = 2, C = 3, D = 4, H = 5, I = 6 with other = 1.
  - seg_controller and the game FSM use the same constants.
- One sub-module: tc_counter, a parameterised modulo-N counter with a terminal-count pulse. It is used for the dwell counter, and for the blink counter when SEG_BLINK_EN is defined.

Test Plan (DWELL = 8, GUARD = 2, BLINK_DIV = 16):
- Reset → an = 1111, other = 1, num = 0, busy = 0. First selected digit is an = 1110 at cycle 3; idx advances every 8 cycles; frame_tick every 32 cycles.
- Write idx0..3 = digits 1, 2, 3, 4 (other = 0) with no commit → outputs stay BLANK for 3 frames. Commit mid-frame → busy = 1 until the next wrap; the following frame shows num 1, 2, 3, 4 under an = 1110, 1101, 1011, 0111.
- Commit asserted on the exact boundary cycle → busy stays 0; the new codes appear in the immediately following frame.
- wr_en idx2 = {1, 5} (H) on the boundary cycle during an applying commit → idx2 keeps its old code this frame; a second commit shows H.
- Assert rst with busy = 1 mid-dwell → next cycle all outputs are at reset values and busy = 0; prior codes are gone.
- SEG_BLINK_EN, blink_mask = 0100 → digit 2's anode stays high during alternate 16-cycle phases; the other anodes scan normally; num for idx2 is still driven.
